// File: rtl/cmp_seq_display_if.sv
// Operand/result bundle for cmp_seq_display: the master drives operands and controls,
// the slave returns status, flags, seven-segment patterns and outcome counts.
interface cmp_seq_display_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    localparam int DIGITS = WIDTH / 4;

    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                load;
    logic                signed_mode;
    logic                clr_cnt;
    logic                busy;
    logic                valid;
    logic                lt;
    logic                eq;
    logic                gt;
    logic [8*DIGITS-1:0] hex_a;
    logic [8*DIGITS-1:0] hex_b;
    logic [7:0]          hex_rel;
    logic [CNT_W-1:0]    lt_cnt;
    logic [CNT_W-1:0]    eq_cnt;
    logic [CNT_W-1:0]    gt_cnt;

    modport master (
        output a, b, load, signed_mode, clr_cnt,
        input  busy, valid, lt, eq, gt, hex_a, hex_b, hex_rel, lt_cnt, eq_cnt, gt_cnt
    );

    modport slave (
        input  a, b, load, signed_mode, clr_cnt,
        output busy, valid, lt, eq, gt, hex_a, hex_b, hex_rel, lt_cnt, eq_cnt, gt_cnt
    );
endinterface

// File: rtl/cmp_seq_display.sv
// Registered unsigned/signed magnitude comparator with active-low seven-segment
// operand digits, an L/E/G relation glyph and saturating outcome counters.
module cmp_seq_display #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input logic              clk,
    input logic              rst,
    cmp_seq_display_if.slave bus
);
    localparam int DIGITS = WIDTH / 4;
    localparam int HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_INIT = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, CMP, SHOW} state_t;

    state_t              state, state_nx;
    logic                capture;
    logic [WIDTH-1:0]    a_r, b_r;
    logic                sm_r;
    logic                lt_r, eq_r, gt_r;
    logic                cmp_lt, cmp_eq, cmp_gt;
    logic [HW-1:0]       hold_cnt;
    logic [CNT_W-1:0]    lt_cnt, eq_cnt, gt_cnt;
    logic [8*DIGITS-1:0] hex_a_c, hex_b_c;
    logic [7:0]          hex_rel_c;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        state_nx = state;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.load) begin
                    state_nx = CMP;
                    capture  = 1'b1;
                end
            end
            CMP:  state_nx = SHOW;
            SHOW: begin
                // A new load restarts even while the hold window is still running.
                if (bus.load) begin
                    state_nx = CMP;
                    capture  = 1'b1;
                end else if (hold_cnt == '0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        if (sm_r) cmp_lt = $signed(a_r) < $signed(b_r);
        else      cmp_lt = a_r < b_r;
        cmp_eq = (a_r == b_r);
        cmp_gt = !cmp_lt && !cmp_eq;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sm_r     <= 1'b0;
            lt_r     <= 1'b0;
            eq_r     <= 1'b0;
            gt_r     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state <= state_nx;
            if (capture) begin
                a_r  <= bus.a;
                b_r  <= bus.b;
                sm_r <= bus.signed_mode;
            end
            if (state == CMP) begin
                lt_r     <= cmp_lt;
                eq_r     <= cmp_eq;
                gt_r     <= cmp_gt;
                hold_cnt <= HOLD_INIT;
            end else if (state == SHOW && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    // Clear takes precedence over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lt_cnt <= '0;
            eq_cnt <= '0;
            gt_cnt <= '0;
        end else if (bus.clr_cnt) begin
            lt_cnt <= '0;
            eq_cnt <= '0;
            gt_cnt <= '0;
        end else if (state == CMP) begin
            if (cmp_lt && lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + 1'b1;
            if (cmp_eq && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
            if (cmp_gt && gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            hex_a_c[8*d +: 8] = seg7(a_r[4*d +: 4]);
            hex_b_c[8*d +: 8] = seg7(b_r[4*d +: 4]);
        end
        // Lit decimal point on the leading digit marks a negative signed operand.
        if (sm_r) begin
            hex_a_c[8*DIGITS-1] = ~a_r[WIDTH-1];
            hex_b_c[8*DIGITS-1] = ~b_r[WIDTH-1];
        end
    end

    always_comb begin
        if (lt_r)      hex_rel_c = 8'hC7;
        else if (eq_r) hex_rel_c = 8'h86;
        else if (gt_r) hex_rel_c = 8'hC2;
        else           hex_rel_c = 8'hFF;
    end

    assign bus.busy    = (state == CMP);
    assign bus.valid   = (state == SHOW);
    assign bus.lt      = lt_r;
    assign bus.eq      = eq_r;
    assign bus.gt      = gt_r;
    assign bus.hex_a   = hex_a_c;
    assign bus.hex_b   = hex_b_c;
    assign bus.hex_rel = hex_rel_c;
    assign bus.lt_cnt  = lt_cnt;
    assign bus.eq_cnt  = eq_cnt;
    assign bus.gt_cnt  = gt_cnt;
endmodule

// File: doc/cmp_seq_display.md
# cmp_seq_display

Parametrised, registered magnitude comparator with seven-segment output for the DE10-Lite board flow. It captures two WIDTH-bit operands on a load strobe and compares them as unsigned or two's-complement values. It shows both operands as active-low hex digits and a relation glyph (L/E/G), and keeps saturating counts of each outcome. It replaces the combinational 4-bit compare/display unit with a clocked, multi-digit, mode-selectable block.

## Interface
- WIDTH, 8, operand width in bits; multiple of 4, range 4..16; DIGITS = WIDTH/4
- HOLD_CYCLES, 4, cycles `valid` stays high per result; ≥1
- CNT_W, 8, width of each outcome counter
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- load  in  1  capture request, sampled on the rising edge
- signed_mode  in  1  1 = two's-complement compare; captured with operands
- clr_cnt  in  1  synchronous clear of the outcome counters
- busy  out  1  high in CMP state
- valid  out  1  high in SHOW state
- lt, eq, gt  out  1 each  one-hot result flags (A<B, A=B, A>B)
- hex_a  out  8*DIGITS  active-low {dp,g..a} digits of captured A; digit 0 in bits [7:0]
- hex_b  out  8*DIGITS  same for captured B
- hex_rel  out  8  relation glyph
- lt_cnt, eq_cnt, gt_cnt  out  CNT_W each  saturating outcome counters

## Operation
- FSM states: IDLE, CMP, SHOW.
  - IDLE -> CMP on load=1. In the same edge, register a, b and signed_mode into a_r, b_r, sm_r.
  - CMP -> SHOW unconditionally. On this edge:
    - Compute the flags from a_r/b_r/sm_r and register them.
    - Increment the matching counter.
    - Load the hold counter with HOLD_CYCLES-1.
  - In SHOW, the hold counter decrements each cycle. SHOW -> IDLE when the counter is 0 and load=0.
  - SHOW with load=1 re-captures the operands and goes to CMP (restart). This takes priority over hold expiry.
  - load in CMP is ignored (no capture, no queueing).
- Compare rules:
  - Unsigned when sm_r=0.
  - Signed when sm_r=1: MSB is the sign; compare as WIDTH-bit two's complement.
- Flags keep their last result through IDLE until the next CMP->SHOW edge.
- hex_rel encoding:
  - 8'b1100_0111 ('L') when lt
  - 8'b1000_0110 ('E') when eq
  - 8'b1100_0010 ('G') when gt
  - 8'b1111_1111 (blank) when no result exists since reset
- Hex digit map (active-low, dp off), values 0..F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- In signed mode, the dp bit (bit 7) of the most-significant digit of hex_a/hex_b is 0 (lit) when that operand is negative. Otherwise it is 1.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_cnt zeroes all three counters.
  - clr_cnt and an increment in the same cycle: clear wins, so the result is 0.

## Timing
- Reset values:
  - State IDLE; a_r, b_r, sm_r = 0.
  - lt, eq, gt = 0; busy = 0; valid = 0.
  - hex_rel = 8'hFF; hex_a and hex_b = all digits 8'hC0.
  - Counters = 0; hold counter = 0.
- Latency:
  - load sampled at edge N.
  - busy=1 after edge N.
  - valid, flags, hex_rel and counters update after edge N+1.
- valid stays high exactly HOLD_CYCLES cycles absent a new load.
- Throughput: one result per 2 cycles when load is held high continuously (CMP, SHOW, CMP, ...).
- hex_a and hex_b update after edge N, from the captured operands. They are combinational decodes of registers, so they are glitch-free relative to clk.
- rst mid-operation (CMP or SHOW) returns all state to reset values immediately. No counter increment happens for the aborted compare.

## Test plan
- Reset, WIDTH=8: rst pulse -> hex_rel=FF, hex_a=C0C0, hex_b=C0C0, counters 0, valid=0.
- Unsigned less-than: a=8'h00, b=8'h01, load 1 cycle, signed_mode=0:
  - busy 1 cycle, then valid for 4 cycles.
  - lt=1, hex_rel=C7, hex_b=C0F9, lt_cnt=1.
- Equal / greater:
  - a=b=8'hAA -> eq=1, hex_rel=86, hex_a=8888, eq_cnt=1.
  - a=8'hA0, b=8'h01, unsigned -> gt=1, hex_rel=C2.
- Signed mode: a=8'hA0, b=8'h01, signed_mode=1 -> lt=1 (−96<1), hex_a=0888_C0 form with bits[15]=0 (dp lit), i.e. hex_a=16'h08C0.
- Back-to-back and ignore rules:
  - load held 6 cycles -> 3 compares, valid pattern 0,1,0,1,0,1.
  - load asserted only in CMP -> ignored, one compare counted.
- Saturation, clear and async reset:
  - CNT_W=2: 5 equal compares -> eq_cnt=3.
  - clr_cnt coincident with a CMP->SHOW edge -> eq_cnt=0.
  - rst asserted during SHOW -> valid drops without waiting for a clock.
